audio_frame_packer: RTL and testbench

Parametrised multi-channel sample-to-byte-stream packer between the TDM receiver / delay-sum path and the byte-level UART transmitter. It replaces the fixed single/dual-mic UART modes with the following features:
- N channels, each selectable by mask.
- Programmable decimation.
- A frame FIFO that absorbs UART backpressure.
- A framed byte stream: sync byte plus sequence number, so the host can detect lost frames.

---
 rtl/audio_stream_pkg.sv | 8 +
 rtl/frame_fifo.sv | 44 ++++
 rtl/audio_frame_packer.sv | 160 ++++++++++++++++
 tb/tb_audio_frame_packer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// audio_stream_pkg: serializer states, default sync byte and frame entry sizing
package audio_stream_pkg;
    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    function automatic int entry_width(input int num_ch, input int out_bytes);
        return num_ch * out_bytes * 8 + num_ch + 8;
    endfunction
endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: synchronous FIFO with registered full flag and simultaneous push/pop
module frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_cnt;
    logic             r_full;
    logic             w_pop;
    logic [CW-1:0]    w_cnt_nxt;
    assign w_pop     = i_pop && !o_empty;
    assign w_cnt_nxt = r_cnt + CW'(i_push) - CW'(w_pop);
    assign o_empty   = r_cnt == '0;
    assign o_full    = r_full;
    assign o_data    = r_mem[r_rd];
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_wr   <= i_push ? r_wr + 1'b1 : r_wr;
            r_rd   <= w_pop ? r_rd + 1'b1 : r_rd;
            r_cnt  <= w_cnt_nxt;
            r_full <= w_cnt_nxt == CW'(DEPTH);
        end
    end
endmodule

// File: rtl/audio_frame_packer.sv
// audio_frame_packer: decimates and masks multi-channel samples into framed bytes
// (sync, seq, payload) through a frame FIFO that absorbs sink backpressure.
module audio_frame_packer
    import audio_stream_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          OUT_BYTES    = 2,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid_in,
    input  logic [NUM_CH-1:0]              ch_mask_in,
    input  logic [7:0]                     decim_in,
    input  logic                           enable_in,
    output logic [7:0]                     byte_out,
    output logic                           byte_valid_out,
    input  logic                           byte_ready_in,
    output logic [15:0]                    drop_count_out,
    output logic                           fifo_full_out
);
    localparam int OW = OUT_BYTES * 8;
    localparam int DW = NUM_CH * OW;
    localparam int EW = entry_width(NUM_CH, OUT_BYTES);
    localparam int NB = NUM_CH * OUT_BYTES;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int BW = OUT_BYTES > 1 ? $clog2(OUT_BYTES) : 1;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;

    logic [7:0]        r_dec, r_seq, r_seq_l;
    logic              r_sel;
    logic [EW-1:0]     r_entry;
    logic [15:0]       r_drop;
    logic [NUM_CH-1:0] r_mask_l;
    logic [DW-1:0]     r_data_l;
    logic [CW-1:0]     r_ch;
    logic [BW-1:0]     r_b;
    state_t            r_state, w_state_nxt;

    logic [DW-1:0]     w_trunc;
    logic [EW-1:0]     w_head;
    logic [7:0]        w_bytes [NB];
    logic [IW-1:0]     w_idx;
    logic [CW-1:0]     w_first, w_next;
    logic              w_has_next, w_take, w_push, w_pop, w_full, w_empty, w_last;
    logic              w_unused;

    assign w_unused = ^sample_in;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_trunc
        assign w_trunc[c*OW +: OW] = sample_in[c*SAMPLE_WIDTH + SAMPLE_WIDTH - OW +: OW];
    end
    // byte j of the payload is byte (j % OUT_BYTES) of channel j / OUT_BYTES, MSB first
    for (genvar j = 0; j < NB; j++) begin : g_bytes
        assign w_bytes[j] = r_data_l[((j / OUT_BYTES) * OUT_BYTES + OUT_BYTES - 1 - (j % OUT_BYTES)) * 8 +: 8];
    end

    assign w_take = sample_valid_in && enable_in && r_dec == '0 && |ch_mask_in;
    assign w_push = r_sel && (!w_full || w_pop);
    assign w_idx  = IW'(r_ch) * IW'(OUT_BYTES) + IW'(r_b);
    assign w_last = r_b == BW'(OUT_BYTES - 1) && !w_has_next;
    assign drop_count_out = r_drop;
    assign fifo_full_out  = w_full;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_dec  <= '0;
            r_seq  <= '0;
            r_sel  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_sel  <= w_take;
            r_dec  <= !enable_in ? '0 : !sample_valid_in ? r_dec : r_dec >= decim_in ? '0 : r_dec + 1'b1;
            r_seq  <= w_take ? r_seq + 1'b1 : r_seq;
            r_drop <= (r_sel && w_full && !w_pop && r_drop != '1) ? r_drop + 1'b1 : r_drop;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_take) r_entry <= {r_seq, ch_mask_in, w_trunc};
    end

    frame_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // descending scan so the lowest qualifying channel wins
    always_comb begin
        w_first    = '0;
        w_next     = '0;
        w_has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask_l[i]) begin
                w_first = CW'(i);
                if (CW'(i) > r_ch) begin
                    w_next     = CW'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        byte_valid_out = 1'b1;
        byte_out       = '0;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                byte_valid_out = 1'b0;
                w_state_nxt    = w_empty ? IDLE : HDR;
            end
            HDR: begin
                byte_out    = SYNC_BYTE;
                w_state_nxt = byte_ready_in ? SEQ : HDR;
            end
            SEQ: begin
                byte_out    = r_seq_l;
                w_state_nxt = byte_ready_in ? DATA : SEQ;
            end
            DATA: begin
                byte_out    = w_bytes[w_idx];
                w_pop       = byte_ready_in && w_last;
                w_state_nxt = w_pop ? IDLE : DATA;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (r_state == IDLE && !w_empty) {r_seq_l, r_mask_l, r_data_l} <= w_head;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ch <= '0;
            r_b  <= '0;
        end else if (r_state == SEQ) begin
            r_ch <= w_first;
            r_b  <= '0;
        end else if (r_state == DATA && byte_ready_in) begin
            r_ch <= r_b == BW'(OUT_BYTES - 1) ? w_next : r_ch;
            r_b  <= r_b == BW'(OUT_BYTES - 1) ? '0 : r_b + 1'b1;
        end
    end
endmodule

// File: tb/tb_audio_frame_packer.sv
// tb_audio_frame_packer: randomized and directed stimulus against a queue-based
// frame model; a separate monitor compares every transferred byte.
module tb_audio_frame_packer;
    localparam int NUM_CH = 4;
    localparam int SW     = 24;
    localparam int OB     = 2;
    localparam int DEPTH  = 4;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic [NUM_CH*SW-1:0]   sample_in;
    logic                   sample_valid_in;
    logic [NUM_CH-1:0]      ch_mask_in;
    logic [7:0]             decim_in;
    logic                   enable_in;
    logic [7:0]             byte_out;
    logic                   byte_valid_out;
    logic                   byte_ready_in;
    logic [15:0]            drop_count_out;
    logic                   fifo_full_out;

    always #5 clk_in = ~clk_in;

    audio_frame_packer #(.NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW), .OUT_BYTES(OB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .ch_mask_in      (ch_mask_in),
        .decim_in        (decim_in),
        .enable_in       (enable_in),
        .byte_out        (byte_out),
        .byte_valid_out  (byte_valid_out),
        .byte_ready_in   (byte_ready_in),
        .drop_count_out  (drop_count_out),
        .fifo_full_out   (fifo_full_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: frames waiting in the FIFO, bytes still owed to the sink
    logic [7:0] exp_q[$];
    logic [7:0] m_pend_bytes[$];
    int         m_lens[$];
    int         m_done = 0, m_drop = 0, m_k = 0, m_frames = 0;
    logic [7:0] m_seq = 8'h00;
    bit         m_pend = 0, m_exp_valid = 0, m_exp_idle = 0;

    always @(negedge clk_in) begin : model
        bit pop;
        logic [SW-1:0] s;
        chk("fifo_full", 32'(fifo_full_out), 32'(m_lens.size() == DEPTH));
        chk("drop_count", 32'(drop_count_out), 32'(m_drop));
        if (m_exp_valid) chk("valid_after_idle", 32'(byte_valid_out), 32'd1);
        if (m_exp_idle)  chk("idle_between_frames", 32'(byte_valid_out), 32'd0);
        m_exp_valid = 0;
        m_exp_idle  = 0;
        if (!rst_in) begin
            exp_q.delete();
            m_lens.delete();
            m_pend_bytes.delete();
            m_done = 0; m_drop = 0; m_k = 0; m_seq = 8'h00; m_pend = 0;
        end else begin
            m_exp_valid = !byte_valid_out && m_lens.size() > 0;
            pop = 0;
            if (byte_valid_out && byte_ready_in && m_lens.size() > 0) begin
                m_done++;
                if (m_done == m_lens[0]) begin
                    void'(m_lens.pop_front());
                    m_done = 0;
                    pop = 1;
                    m_frames++;
                end
            end
            m_exp_idle = pop;
            if (m_pend) begin
                if (m_lens.size() < DEPTH) begin
                    m_lens.push_back(m_pend_bytes.size());
                    foreach (m_pend_bytes[i]) exp_q.push_back(m_pend_bytes[i]);
                end else if (m_drop < 65535) m_drop++;
            end
            m_pend = 0;
            m_pend_bytes.delete();
            if (!enable_in) m_k = 0;
            else if (sample_valid_in) begin
                if (m_k % (int'(decim_in) + 1) == 0 && ch_mask_in != '0) begin
                    m_pend_bytes.push_back(8'hA5);
                    m_pend_bytes.push_back(m_seq);
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ch_mask_in[c]) begin
                            s = sample_in[c*SW +: SW];
                            for (int b = 0; b < OB; b++) m_pend_bytes.push_back(s[SW-1-8*b -: 8]);
                        end
                    end
                    m_pend = 1;
                    m_seq++;
                end
                m_k++;
            end
        end
    end

    logic [7:0] prev_byte = 8'h00;
    bit         stall_prev = 0;

    always @(negedge clk_in) begin : monitor
        #1;
        if (!rst_in) stall_prev = 0;
        else begin
            if (stall_prev) begin
                chk("stall_valid_held", 32'(byte_valid_out), 32'd1);
                chk("stall_byte_held", 32'(byte_out), 32'(prev_byte));
            end
            if (byte_valid_out) begin
                chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (byte_ready_in && exp_q.size() != 0) chk("stream_byte", 32'(byte_out), 32'(exp_q.pop_front()));
            end
            stall_prev = byte_valid_out && !byte_ready_in;
            prev_byte  = byte_out;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic logic [NUM_CH*SW-1:0] rand_samples();
        logic [NUM_CH*SW-1:0] s;
        for (int c = 0; c < NUM_CH; c++) s[c*SW +: SW] = SW'($urandom);
        return s;
    endfunction

    task automatic strobe(input logic [NUM_CH*SW-1:0] s);
        sample_in       = s;
        sample_valid_in = 1'b1;
        cyc(1);
        sample_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        cyc(2);
        rst_in = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_lens.size() != 0 || m_pend) && t < 3000) begin
            cyc(1);
            t++;
        end
        chk("drain_within_budget", 32'(t < 3000), 32'd1);
        cyc(2);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!byte_valid_out && lat < 20) begin
            cyc(1);
            lat++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [NUM_CH*SW-1:0] s;
        int lat, f0;
        rst_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0; ch_mask_in = '0;
        decim_in = 8'd0; enable_in = 1'b0; byte_ready_in = 1'b1;
        cyc(3);
        chk("reset_valid", 32'(byte_valid_out), 32'd0);
        chk("reset_byte", 32'(byte_out), 32'd0);
        chk("reset_drop", 32'(drop_count_out), 32'd0);
        chk("reset_full", 32'(fifo_full_out), 32'd0);
        rst_in = 1'b1; enable_in = 1'b1; ch_mask_in = 4'b0011;
        cyc(2);

        s = rand_samples();
        s[0 +: SW]  = 24'h123456;
        s[SW +: SW] = 24'hABCDEF;
        strobe(s);
        wait_valid(lat);
        chk("first_byte_latency", 32'(lat), 32'd2);
        chk("first_byte_sync", 32'(byte_out), 32'hA5);
        drain();

        do_reset();
        ch_mask_in = 4'b1111; decim_in = 8'd2;
        f0 = m_frames;
        for (int i = 0; i < 9; i++) begin
            strobe(rand_samples());
            cyc(12);
        end
        drain();
        chk("decim_frame_count", 32'(m_frames - f0), 32'd3);

        do_reset();
        decim_in = 8'd0; byte_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe(rand_samples());
            cyc(1);
        end
        cyc(3);
        chk("stalled_fifo_full", 32'(fifo_full_out), 32'd1);
        chk("stalled_drops", 32'(drop_count_out), 32'd2);
        byte_ready_in = 1'b1;
        drain();
        strobe(rand_samples());
        wait_valid(lat);
        cyc(1);
        chk("seq_after_drops", 32'(byte_out), 32'h06);
        drain();

        strobe(rand_samples());
        wait_valid(lat);
        cyc(4);
        rst_in = 1'b0;
        cyc(1);
        rst_in = 1'b1;
        chk("midframe_reset_valid", 32'(byte_valid_out), 32'd0);
        chk("midframe_reset_drop", 32'(drop_count_out), 32'd0);
        chk("midframe_reset_byte", 32'(byte_out), 32'd0);
        strobe(rand_samples());
        wait_valid(lat);
        chk("post_reset_sync", 32'(byte_out), 32'hA5);
        cyc(1);
        chk("post_reset_seq", 32'(byte_out), 32'h00);
        drain();

        for (int i = 0; i < 240; i++) begin
            byte_ready_in   = i[0];
            sample_valid_in = (i % 30 == 0);
            if (sample_valid_in) begin
                sample_in  = rand_samples();
                ch_mask_in = 4'($urandom_range(1, 15));
            end
            cyc(1);
        end
        sample_valid_in = 1'b0; byte_ready_in = 1'b1;
        drain();

        ch_mask_in = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            strobe(rand_samples());
            cyc(3);
        end
        cyc(10);
        chk("mask0_no_drop", 32'(drop_count_out), 32'd0);
        chk("mask0_no_output", 32'(byte_valid_out), 32'd0);
        ch_mask_in = 4'b1111;
        strobe(rand_samples());
        wait_valid(lat);
        cyc(1);
        chk("mask0_seq_unchanged", 32'(byte_out), 32'h09);
        drain();

        do_reset();
        for (int r = 0; r < 6; r++) begin
            enable_in = 1'b0;
            decim_in  = 8'($urandom_range(0, 3));
            cyc(1);
            enable_in = 1'b1;
            for (int i = 0; i < 50; i++) begin
                sample_in       = rand_samples();
                ch_mask_in      = 4'($urandom_range(0, 15));
                sample_valid_in = 1'b1;
                byte_ready_in   = $urandom_range(0, 3) != 0;
                cyc(1);
                sample_valid_in = 1'b0;
                repeat ($urandom_range(0, 6)) begin
                    byte_ready_in = $urandom_range(0, 3) != 0;
                    cyc(1);
                end
            end
        end
        byte_ready_in = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
